// File: rtl/slice_round_scheduler.sv
// slice_round_scheduler
//
// Sequences the slice datapath through a full multi-round permutation:
//   1. LOAD:  copies 64 input lines into bank 0 of the two-bank slice buffer.
//   2. Steps: runs NUM_STEPS step units per round. The source bank flips after
//      every step, so the output of one step is the input of the next.
//   3. DRAIN: reads the final bank back one line at a time and hands each line
//      to the output writer.
// This block owns every buffer address and the bank-select.
//
// Optional feature macro: TIMEOUT_WATCHDOG_EN
//   Defined:     a watchdog limits each WAIT to TIMEOUT cycles. On expiry the
//                block raises error and goes straight to DONE without draining.
//   Not defined: WAIT can hold indefinitely and error is tied to 0.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           level request, sampled in IDLE
//   num_rounds      round count, latched when start is accepted
//   done            completion flag, held while start stays high after the run
//   busy            high in every state except IDLE and DONE
//   cnt_value       input line-memory address; line_in returns its data
//                   combinationally
//   line_in         input line data for cnt_value
//   buf_we          slice buffer write enable
//   buf_addr        slice buffer line address
//   buf_wdata       slice buffer write data
//   buf_bank        slice buffer bank select; during steps, the source bank
//   buf_rdata       slice buffer read data, 1-cycle synchronous read of
//                   {buf_bank, buf_addr}
//   step_start      one-cycle pulse that launches a step unit
//   step_sel        index of the step unit being launched
//   round_idx       current round, 0-based
//   step_done       step unit finished
//   write_enable    one-cycle pulse per output line
//   write_value     output line, valid while write_enable is high
//   error           step timeout flag

module slice_round_scheduler #(
    parameter int DATA_W    = 25,
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = 6,
    parameter int NUM_STEPS = 5
`ifdef TIMEOUT_WATCHDOG_EN
    ,
    parameter int TIMEOUT   = 255
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        num_rounds,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] cnt_value,
    input  logic [DATA_W-1:0] line_in,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [DATA_W-1:0] buf_wdata,
    output logic              buf_bank,
    input  logic [DATA_W-1:0] buf_rdata,
    output logic              step_start,
    output logic [2:0]        step_sel,
    output logic [4:0]        round_idx,
    input  logic              step_done,
    output logic              write_enable,
    output logic [DATA_W-1:0] write_value,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LAUNCH,
        S_WAIT,
        S_ADVANCE,
        S_DRAIN_ADDR,
        S_DRAIN_EMIT,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(DEPTH - 1);
    localparam logic [2:0]        LAST_STEP = 3'(NUM_STEPS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] c_q, c_d;
    logic [2:0]        s_q, s_d;
    logic [4:0]        r_q, r_d;
    logic [4:0]        rounds_q, rounds_d;
    logic              bank_q, bank_d;

`ifdef TIMEOUT_WATCHDOG_EN
    // The watchdog counts WAIT cycles. Its last value is TIMEOUT-1, so a step
    // that never finishes is abandoned after exactly TIMEOUT WAIT cycles.
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wd_q, wd_d;
    logic       error_q, error_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            c_q      <= '0;
            s_q      <= '0;
            r_q      <= '0;
            rounds_q <= '0;
            bank_q   <= 1'b0;
`ifdef TIMEOUT_WATCHDOG_EN
            wd_q     <= '0;
            error_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            s_q      <= s_d;
            r_q      <= r_d;
            rounds_q <= rounds_d;
            bank_q   <= bank_d;
`ifdef TIMEOUT_WATCHDOG_EN
            wd_q     <= wd_d;
            error_q  <= error_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        c_d          = c_q;
        s_d          = s_q;
        r_d          = r_q;
        rounds_d     = rounds_q;
        bank_d       = bank_q;
`ifdef TIMEOUT_WATCHDOG_EN
        wd_d         = wd_q;
        error_d      = error_q;
`endif
        done         = 1'b0;
        cnt_value    = '0;
        buf_we       = 1'b0;
        buf_addr     = '0;
        buf_wdata    = '0;
        buf_bank     = bank_q;
        step_start   = 1'b0;
        write_enable = 1'b0;
        write_value  = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rounds_d = num_rounds;
                    c_d      = '0;
                    s_d      = '0;
                    r_d      = '0;
                    bank_d   = 1'b0;
`ifdef TIMEOUT_WATCHDOG_EN
                    error_d  = 1'b0;
`endif
                    state_d  = S_LOAD;
                end
            end

            S_LOAD: begin
                cnt_value = c_q;
                buf_we    = 1'b1;
                buf_bank  = 1'b0;
                buf_addr  = c_q;
                buf_wdata = line_in;
                // The line counter wraps to 0 on the last line, so the drain
                // starts from line 0 without an explicit clear.
                c_d       = c_q + ADDR_W'(1);
                if (c_q == LAST_LINE) begin
                    state_d = (rounds_q == 5'd0) ? S_DRAIN_ADDR : S_LAUNCH;
                end
            end

            S_LAUNCH: begin
                step_start = 1'b1;
`ifdef TIMEOUT_WATCHDOG_EN
                wd_d       = '0;
`endif
                state_d    = S_WAIT;
            end

            S_WAIT: begin
                if (step_done) begin
                    state_d = S_ADVANCE;
                end
`ifdef TIMEOUT_WATCHDOG_EN
                else if (wd_q == WD_LAST) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
`endif
            end

            S_ADVANCE: begin
                // The step wrote the other bank, so that bank is the source
                // for the next step (or for the drain).
                bank_d = ~bank_q;
                if (s_q < LAST_STEP) begin
                    s_d     = s_q + 3'd1;
                    state_d = S_LAUNCH;
                end else begin
                    s_d     = '0;
                    r_d     = r_q + 5'd1;
                    state_d = ((r_q + 5'd1) == rounds_q) ? S_DRAIN_ADDR : S_LAUNCH;
                end
            end

            S_DRAIN_ADDR: begin
                buf_addr = c_q;
                state_d  = S_DRAIN_EMIT;
            end

            S_DRAIN_EMIT: begin
                // The buffer read has a latency of one cycle, so the data for
                // the address presented in DRAIN_ADDR is on buf_rdata now.
                buf_addr     = c_q;
                write_enable = 1'b1;
                write_value  = buf_rdata;
                c_d          = c_q + ADDR_W'(1);
                state_d      = (c_q == LAST_LINE) ? S_DONE : S_DRAIN_ADDR;
            end

            S_DONE: begin
                // The block leaves DONE only after start drops, so a start
                // that is still held cannot launch a second run.
                done = 1'b1;
                if (!start) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign step_sel  = s_q;
    assign round_idx = r_q;

`ifdef TIMEOUT_WATCHDOG_EN
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: doc/slice_round_scheduler.md
# slice_round_scheduler

Sequences the matrix-encoder slice datapath through a full multi-round permutation. It loads 64 × 25-bit slice lines from the input line memory into a two-bank slice buffer, then runs NUM_STEPS step units per round, swapping the source bank between steps. Finally it drains the result to the output writer. It sits between the top-level start/done handshake and the step datapath and owns every buffer address and the bank-select.

## Interface
- DATA_W, 25, slice line width (5×5 lane bits)
- DEPTH, 64, lines per state; ADDR_W = 6
- NUM_STEPS, 5, step units per round; step_sel values 0..NUM_STEPS-1
- TIMEOUT, 255, max cycles waited for step_done (macro build only)

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  level request; sampled in IDLE
- num_rounds  in  5  rounds to run; latched when start is accepted
- done  out  1  sticky completion flag
- busy  out  1  high in every state except IDLE and DONE
- cnt_value  out  6  input line-memory address (combinational read)
- line_in  in  25  input line data for cnt_value
- buf_we / buf_addr / buf_wdata / buf_bank  out  1/6/25/1  slice buffer port
- buf_rdata  in  25  buffer read data, 1-cycle synchronous read of {buf_bank, buf_addr}
- step_start  out  1  one-cycle pulse launching a step
- step_sel  out  3  step unit index
- round_idx  out  5  current round, 0-based
- step_done  in  1  step unit finished (reads bank buf_bank, writes ~buf_bank)
- write_enable  out  1  one-cycle pulse per output line
- write_value  out  25  output line, valid while write_enable is high
- error  out  1  step timeout flag (TIMEOUT_WATCHDOG_EN only; tied 0 otherwise)

## Operation
- States: IDLE, LOAD, LAUNCH, WAIT, ADVANCE, DRAIN_ADDR, DRAIN_EMIT, DONE.
- IDLE: if start=1, latch num_rounds, clear counters, set bank to 0, go to LOAD.
- LOAD: line counter c runs 0..63. Each cycle drives cnt_value=c, buf_we=1, buf_bank=0, buf_addr=c, buf_wdata=line_in. When c=63, go to LAUNCH, or to DRAIN_ADDR if num_rounds=0.
- LAUNCH: step_start=1 for one cycle with step_sel=s and round_idx=r. buf_bank holds the source bank. Go to WAIT.
- WAIT: holds until step_done=1, then goes to ADVANCE. step_done outside WAIT is ignored.
- ADVANCE: toggle bank. If s<NUM_STEPS-1, increment s. Otherwise set s=0 and increment r. If r+1=num_rounds, go to DRAIN_ADDR; otherwise go to LAUNCH.
- DRAIN_ADDR: buf_addr=c and buf_bank=final bank, then go to DRAIN_EMIT.
- DRAIN_EMIT: write_value=buf_rdata and write_enable=1, then increment c. At c=63 go to DONE; otherwise go back to DRAIN_ADDR. write_enable therefore toggles every other cycle, giving one rising edge per line.
- DONE: done=1 while start stays high. When start=0, go to IDLE with done=0. A held start never retriggers.
- Counters: c is 6 bits and wraps only at the 63→exit transition. s is 3 bits. r is 5 bits. Round comparisons use the latched num_rounds.

## Timing
- Reset: state IDLE. All outputs are 0: done, busy, cnt_value, buf_*, step_*, round_idx, write_*, error.
- rst=1 at any cycle aborts the operation on the next edge. The buffer contents are left as they are. No write_enable or step_start is issued after reset.
- start accepted at edge 0: LOAD spans cycles 1–64, and the first step_start occurs in cycle 65.
- Per step: 1 LAUNCH + (step unit latency L ≥ 1 in WAIT) + 1 ADVANCE.
- Drain: 128 cycles. The first write_enable comes 2 cycles after leaving the last ADVANCE (or LOAD).
- Total with num_rounds=R: 64 + R·NUM_STEPS·(L+2) + 128 cycles, then done rises on the next cycle.
- step_done asserted in the LAUNCH cycle is ignored. The step unit must hold step_done or re-pulse it once the block is in WAIT.

## Configuration
- TIMEOUT_WATCHDOG_EN defined: an 8-bit counter runs in WAIT. If it reaches TIMEOUT without step_done, the block sets error=1 and goes straight to DONE with no drain. error clears only on rst or on the next accepted start.
- Not defined: WAIT can hold indefinitely and error is constant 0.

## Test plan
- Reset mid-LOAD at c=20 → next cycle IDLE, all outputs 0, no buf_we.
- num_rounds=0, line k = k → after LOAD, 64 write_enable pulses with write_value = 0..63 in order, then done=1.
- num_rounds=2, stub step unit with L=3 → exactly 10 step_start pulses, step_sel 0..4 twice, round_idx 0,0,0,0,0,1,…, buf_bank alternating and starting at 0. Draining starts from bank 0, because 10 swaps leave it there.
- start held high after done → done stays 1 and there is no second LOAD. Drop start → IDLE next cycle.
- step_done pulsed during LAUNCH and during LOAD → ignored, state unchanged.
- TIMEOUT_WATCHDOG_EN, step_done never asserted → error=1 and done=1 after 255 WAIT cycles, zero write_enable pulses.
